handle_game_end: RTL

- Parametrised successor of the single-mode win detector in GameControl; decides game end for either board of the two-board card game.
- Supports two win modes (empty hand / hand at or below a threshold), a guaranteed-delivery WIN broadcast with timeout and retry, deterministic tie-break, and reports winner ID and link failure.
- Sits beside the other GameControl handlers; its ctrl_* bus is muxed into the interboard transmitter like every other handler.

---
 rtl/handle_game_end.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/handle_game_end.sv
// Game-end detector for one board: declares a local win, broadcasts it with
// timeout/retry, and resolves simultaneous wins in favour of player 0.
module handle_game_end #(
    parameter int unsigned PLAYER     = 0,
    parameter int unsigned CNT_W      = 7,
    parameter int unsigned WIN_MODE   = 0,
    parameter int unsigned WIN_CARDS  = 0,
    parameter logic [3:0]  STATE_PLAY = 4'd3,
    parameter logic [3:0]  MSG_WIN    = 4'd9,
    parameter int unsigned TIMEOUT    = 1000,
    parameter int unsigned RETRY_MAX  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             interboard_rst,
    input  logic             done_and_next,
    input  logic [CNT_W-1:0] my_card_cnt,
    input  logic [3:0]       cur_game_state,
    input  logic             inter_ready,
    input  logic             interboard_en,
    input  logic [3:0]       interboard_msg_type,
    output logic             one_win,
    output logic             game_over,
    output logic             winner,
    output logic             link_err,
    output logic             ctrl_en,
    output logic             ctrl_move_dir,
    output logic [3:0]       ctrl_msg_type,
    output logic [5:0]       ctrl_card,
    output logic [2:0]       ctrl_sel_len,
    output logic [4:0]       ctrl_block_x,
    output logic [2:0]       ctrl_block_y
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int RW = ($clog2(RETRY_MAX + 1) > 0) ? $clog2(RETRY_MAX + 1) : 1;
    localparam logic [TW-1:0]    TO_LAST   = TW'(TIMEOUT - 1);
    localparam logic [RW-1:0]    RETRY_LIM = RW'(RETRY_MAX);
    localparam logic [CNT_W-1:0] WIN_TH    = CNT_W'(WIN_CARDS);
    localparam logic             P_ID      = (PLAYER != 0);

    typedef enum logic [2:0] {IDLE, SEND, WAIT_ACC, WAIT_DONE, OVER} state_t;

    state_t        r_state, w_state_n;
    logic          r_one_win, w_one_win_n;
    logic          r_game_over, w_game_over_n;
    logic          r_winner, w_winner_n;
    logic          r_link_err, w_link_err_n;
    logic          r_ctrl_en, w_ctrl_en_n;
    logic [5:0]    r_card, w_card_n;
    logic [TW-1:0] r_cnt, w_cnt_n;
    logic [RW-1:0] r_retry, w_retry_n;

    logic        w_rst;
    logic        w_win_cond;
    logic        w_rx_win;
    logic        w_abandon;
    logic [31:0] w_cnt_ext;
    logic [5:0]  w_card_sat;

    assign w_rst      = rst | interboard_rst;
    assign w_win_cond = done_and_next && (cur_game_state == STATE_PLAY) &&
                        ((WIN_MODE != 0) ? (my_card_cnt <= WIN_TH) : (my_card_cnt == '0));
    assign w_rx_win   = interboard_en && (interboard_msg_type == MSG_WIN) &&
                        (cur_game_state == STATE_PLAY);
    assign w_abandon  = w_rx_win && P_ID;
    assign w_cnt_ext  = 32'(my_card_cnt);
    assign w_card_sat = (w_cnt_ext > 32'd63) ? 6'd63 : w_cnt_ext[5:0];

    always_ff @(posedge clk) begin
        if (w_rst) begin
            r_state     <= IDLE;
            r_one_win   <= 1'b0;
            r_game_over <= 1'b0;
            r_winner    <= 1'b0;
            r_link_err  <= 1'b0;
            r_ctrl_en   <= 1'b0;
            r_card      <= '0;
            r_cnt       <= '0;
            r_retry     <= '0;
        end else begin
            r_state     <= w_state_n;
            r_one_win   <= w_one_win_n;
            r_game_over <= w_game_over_n;
            r_winner    <= w_winner_n;
            r_link_err  <= w_link_err_n;
            r_ctrl_en   <= w_ctrl_en_n;
            r_card      <= w_card_n;
            r_cnt       <= w_cnt_n;
            r_retry     <= w_retry_n;
        end
    end

    always_comb begin
        w_state_n     = r_state;
        w_one_win_n   = r_one_win;
        w_game_over_n = r_game_over;
        w_winner_n    = r_winner;
        w_link_err_n  = r_link_err;
        w_ctrl_en_n   = 1'b0;
        w_card_n      = r_card;
        w_cnt_n       = r_cnt;
        w_retry_n     = r_retry;

        case (r_state)
            IDLE: begin
                if (w_rx_win && (P_ID || !w_win_cond)) begin
                    w_state_n     = OVER;
                    w_game_over_n = 1'b1;
                    w_winner_n    = ~P_ID;
                end else if (w_win_cond) begin
                    w_state_n   = SEND;
                    w_one_win_n = 1'b1;
                    w_card_n    = w_card_sat;
                    w_cnt_n     = '0;
                    w_retry_n   = '0;
                end
            end
            SEND: begin
                if (inter_ready) begin
                    w_ctrl_en_n = 1'b1;
                    w_cnt_n     = '0;
                    w_state_n   = WAIT_ACC;
                end
            end
            WAIT_ACC: begin
                if (!inter_ready) begin
                    w_cnt_n   = '0;
                    w_state_n = WAIT_DONE;
                end else if (r_cnt == TO_LAST) begin
                    if (r_retry < RETRY_LIM) begin
                        w_retry_n = r_retry + 1'b1;
                        w_state_n = SEND;
                    end else begin
                        w_link_err_n  = 1'b1;
                        w_game_over_n = 1'b1;
                        w_winner_n    = P_ID;
                        w_state_n     = OVER;
                    end
                end else begin
                    w_cnt_n = r_cnt + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (inter_ready) begin
                    w_game_over_n = 1'b1;
                    w_winner_n    = P_ID;
                    w_state_n     = OVER;
                end else if (r_cnt == TO_LAST) begin
                    w_link_err_n  = 1'b1;
                    w_game_over_n = 1'b1;
                    w_winner_n    = P_ID;
                    w_state_n     = OVER;
                end else begin
                    w_cnt_n = r_cnt + 1'b1;
                end
            end
            OVER: ;
            default: w_state_n = IDLE;
        endcase

        // Board 1 yields to a remote win at any point of its own broadcast.
        if (w_abandon && (r_state inside {SEND, WAIT_ACC, WAIT_DONE})) begin
            w_state_n     = OVER;
            w_game_over_n = 1'b1;
            w_winner_n    = ~P_ID;
            w_one_win_n   = 1'b0;
            w_ctrl_en_n   = 1'b0;
        end
    end

    assign one_win       = r_one_win;
    assign game_over     = r_game_over;
    assign winner        = r_winner;
    assign link_err      = r_link_err;
    assign ctrl_en       = r_ctrl_en;
    assign ctrl_msg_type = r_ctrl_en ? MSG_WIN : '0;
    assign ctrl_card     = r_card;
    assign ctrl_move_dir = 1'b0;
    assign ctrl_sel_len  = '0;
    assign ctrl_block_x  = '0;
    assign ctrl_block_y  = '0;

endmodule
